// File: rtl/mdu_param_if.sv
// Handshake and HI/LO bus between the execute stage and the multiply/divide unit.
interface mdu_param_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [2:0]       mdu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             we;
  logic             hilo_sel;
  logic [WIDTH-1:0] wdata;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, mdu_op, a, b, we, hilo_sel, wdata, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, mdu_op, a, b, we, hilo_sel, wdata, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_param.sv
// Multi-cycle multiply/divide/accumulate unit owning the HI/LO pair.
// Define MDU_ACC_EN to enable MADD/MADDU/MSUB/MSUBU accumulation.
module mdu_param #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic        clk,
  input logic        reset,
  mdu_param_if.slave bus
);

  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, hi_nxt, lo_q, lo_nxt;
  logic             busy_q, busy_nxt, done_q, done_nxt;
  logic             latch;
`ifdef MDU_ACC_EN
  logic [W2-1:0]    acc_q;
  logic [W2-1:0]    acc_sum;
`endif

  logic             is_signed, is_div, div_zero, start_div;
  logic [W2-1:0]    ext_a, ext_b, prod, result;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b, mag_b_safe, quot_m, rem_m, quot, rem;

  // Datapath evaluated from the operands captured at start
  always_comb begin
    is_signed  = ~op_q[0];
    is_div     = ~op_q[2] & op_q[1];
    ext_a      = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {WIDTH'(0), a_q};
    ext_b      = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {WIDTH'(0), b_q};
    prod       = ext_a * ext_b;
    neg_a      = is_signed & a_q[WIDTH-1];
    neg_b      = is_signed & b_q[WIDTH-1];
    mag_a      = neg_a ? (WIDTH'(0) - a_q) : a_q;
    mag_b      = neg_b ? (WIDTH'(0) - b_q) : b_q;
    div_zero   = (b_q == WIDTH'(0));
    mag_b_safe = div_zero ? WIDTH'(1) : mag_b;
    // Magnitude divide; MIN/-1 wraps back to MIN with zero remainder
    quot_m     = mag_a / mag_b_safe;
    rem_m      = mag_a % mag_b_safe;
    quot       = (neg_a ^ neg_b) ? (WIDTH'(0) - quot_m) : quot_m;
    rem        = neg_a ? (WIDTH'(0) - rem_m) : rem_m;
`ifdef MDU_ACC_EN
    acc_sum    = op_q[1] ? (acc_q - prod) : (acc_q + prod);
    if (is_div)       result = {rem, quot};
    else if (op_q[2]) result = acc_sum;
    else              result = prod;
`else
    result     = is_div ? {rem, quot} : prod;
`endif
  end

  assign start_div = ~bus.mdu_op[2] & bus.mdu_op[1];

  // Next-state and registered-output logic
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    latch     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          cnt_nxt   = start_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
          busy_nxt  = 1'b1;
          latch     = 1'b1;
        end else if (bus.we) begin
          if (bus.hilo_sel) hi_nxt = bus.wdata;
          else              lo_nxt = bus.wdata;
        end
      end
      RUN: begin
        if (bus.cancel) begin
          state_nxt = IDLE;
          cnt_nxt   = CW'(0);
        end else if (cnt_q == CW'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = CW'(0);
          done_nxt  = 1'b1;
          if (!(is_div && div_zero)) begin
            hi_nxt = result[W2-1:WIDTH];
            lo_nxt = result[WIDTH-1:0];
          end
        end else begin
          cnt_nxt  = cnt_q - CW'(1);
          busy_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CW'(0);
      hi_q    <= WIDTH'(0);
      lo_q    <= WIDTH'(0);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  // Operand capture so later input changes cannot disturb the op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= 3'b000;
      a_q   <= WIDTH'(0);
      b_q   <= WIDTH'(0);
`ifdef MDU_ACC_EN
      acc_q <= W2'(0);
`endif
    end else if (latch) begin
      op_q  <= bus.mdu_op;
      a_q   <= bus.a;
      b_q   <= bus.b;
`ifdef MDU_ACC_EN
      acc_q <= {hi_q, lo_q};
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
